// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch/sequence stage: state encoding,
// reserved opcodes and instruction-word field positions.
package fetch_pkg;

  localparam int PC_W_DEF      = 4;
  localparam int REG_SEL_W_DEF = 2;
  localparam int OP_W          = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_SETTLE = 2'd2,
    ST_HALTED = 2'd3
  } fetch_state_t;

  localparam logic [OP_W-1:0] OP_NOP    = 4'hF;
  localparam logic [OP_W-1:0] OP_SKIPIF = 4'd9;
  localparam logic [OP_W-1:0] OP_HALT   = 4'd10;

  // Instruction word is {opcode, rd, rs}; positions derived from the select width.
  function automatic int instr_w(input int reg_sel_w);
    return OP_W + 2 * reg_sel_w;
  endfunction

  function automatic int op_lsb(input int reg_sel_w);
    return 2 * reg_sel_w;
  endfunction

  function automatic int rd_lsb(input int reg_sel_w);
    return reg_sel_w;
  endfunction

  localparam int RS_LSB = 0;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Bus bundle between the fetch sequencer and its controller/decoder side.
// The sequencer connects through the slave modport, the environment through master.
interface fetch_sequencer_if #(
  parameter int PC_W      = 4,
  parameter int REG_SEL_W = 2
);
  localparam int INSTR_W = 4 + 2 * REG_SEL_W;

  logic                 run;
  logic                 wr_en;
  logic [PC_W-1:0]      wr_addr;
  logic [INSTR_W-1:0]   wr_data;
  logic                 skip_in;
  logic                 halt_in;

  logic [3:0]           op_code;
  logic                 op_valid;
  logic [REG_SEL_W-1:0] rd_sel;
  logic [REG_SEL_W-1:0] rs_sel;
  logic [PC_W-1:0]      pc;
  logic                 busy;
  logic                 halted;
  logic                 wr_rej;
  logic [15:0]          retired;

  modport master (
    output run, wr_en, wr_addr, wr_data, skip_in, halt_in,
    input  op_code, op_valid, rd_sel, rs_sel, pc, busy, halted, wr_rej, retired
  );

  modport slave (
    input  run, wr_en, wr_addr, wr_data, skip_in, halt_in,
    output op_code, op_valid, rd_sel, rs_sel, pc, busy, halted, wr_rej, retired
  );

endinterface

// File: rtl/fetch_imem.sv
// Program memory: register array with one synchronous write port and one
// combinational read port. Contents are deliberately not reset.
module fetch_imem #(
  parameter int PC_W    = 4,
  parameter int INSTR_W = 8
) (
  input  logic               i_clk,
  input  logic               i_we,
  input  logic [PC_W-1:0]    i_wr_addr,
  input  logic [INSTR_W-1:0] i_wr_data,
  input  logic [PC_W-1:0]    i_rd_addr,
  output logic [INSTR_W-1:0] o_rd_data
);

  logic [INSTR_W-1:0] r_mem [2**PC_W];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch/sequence stage: issues one opcode per two cycles and
// advances the PC by 1 or 2 (or halts) from the decoder flags.
// Optional retired-instruction counter is built when FETCH_RETIRE_CNT_EN is defined.
//
// state     | meaning
// ST_IDLE   | after reset; program writes accepted, waits for run
// ST_ISSUE  | opcode of mem[pc] presented, op_valid high
// ST_SETTLE | NOP presented so decoder flags settle; halt/skip sampled at end
// ST_HALTED | decoder requested halt; writes accepted, run restarts at pc 0
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int PC_W      = PC_W_DEF,
  parameter int REG_SEL_W = REG_SEL_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_reset,
  fetch_sequencer_if.slave  bus
);

  localparam int INSTR_W = instr_w(REG_SEL_W);
  localparam int OP_LSB  = op_lsb(REG_SEL_W);
  localparam int RD_LSB  = rd_lsb(REG_SEL_W);

  localparam logic [PC_W-1:0] PC_ZERO = '0;
  localparam logic [PC_W-1:0] PC_ONE  = PC_W'(1);
  localparam logic [PC_W-1:0] PC_TWO  = PC_W'(2);

  fetch_state_t         r_state;
  fetch_state_t         w_state_nxt;
  logic [PC_W-1:0]      r_pc;
  logic [PC_W-1:0]      w_pc_nxt;
  logic [3:0]           r_op_code;
  logic                 r_op_valid;
  logic [REG_SEL_W-1:0] r_rd_sel;
  logic [REG_SEL_W-1:0] r_rs_sel;
  logic                 r_busy;
  logic                 r_halted;
  logic                 r_wr_rej;

  logic                 w_idle_like;
  logic                 w_mem_we;
  logic                 w_start;
  logic                 w_wr_reject;
  logic                 w_enter_issue;
  logic [INSTR_W-1:0]   w_rd_data;

  assign w_idle_like = (r_state == ST_IDLE) || (r_state == ST_HALTED);
  assign w_mem_we    = w_idle_like && bus.wr_en;
  // A concurrent write takes precedence, so run is only honoured with wr_en low.
  assign w_start     = w_idle_like && bus.run && !bus.wr_en;
  assign w_wr_reject = !w_idle_like && bus.wr_en;

  fetch_imem #(
    .PC_W    (PC_W),
    .INSTR_W (INSTR_W)
  ) u_imem (
    .i_clk     (i_clk),
    .i_we      (w_mem_we),
    .i_wr_addr (bus.wr_addr),
    .i_wr_data (bus.wr_data),
    .i_rd_addr (w_pc_nxt),
    .o_rd_data (w_rd_data)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    case (r_state)
      ST_IDLE, ST_HALTED: begin
        if (w_start) begin
          w_state_nxt = ST_ISSUE;
          w_pc_nxt    = PC_ZERO;
        end
      end
      ST_ISSUE: begin
        w_state_nxt = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (bus.halt_in) begin
          w_state_nxt = ST_HALTED;
        end else if (bus.skip_in) begin
          w_state_nxt = ST_ISSUE;
          w_pc_nxt    = r_pc + PC_TWO;
        end else begin
          w_state_nxt = ST_ISSUE;
          w_pc_nxt    = r_pc + PC_ONE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign w_enter_issue = (w_state_nxt == ST_ISSUE);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Output registers: the read port already addresses the next PC, so the
  // fetched word lands here on the same edge that enters ISSUE.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_pc       <= '0;
      r_op_code  <= OP_NOP;
      r_op_valid <= 1'b0;
      r_rd_sel   <= '0;
      r_rs_sel   <= '0;
      r_busy     <= 1'b0;
      r_halted   <= 1'b0;
      r_wr_rej   <= 1'b0;
    end else begin
      r_pc       <= w_pc_nxt;
      r_op_code  <= w_enter_issue ? w_rd_data[OP_LSB +: 4] : OP_NOP;
      r_op_valid <= w_enter_issue;
      if (w_enter_issue) begin
        r_rd_sel <= w_rd_data[RD_LSB +: REG_SEL_W];
        r_rs_sel <= w_rd_data[RS_LSB +: REG_SEL_W];
      end
      r_busy     <= (w_state_nxt == ST_ISSUE) || (w_state_nxt == ST_SETTLE);
      r_halted   <= (w_state_nxt == ST_HALTED);
      r_wr_rej   <= w_wr_reject;
    end
  end

`ifdef FETCH_RETIRE_CNT_EN
  logic [15:0] r_retired;
  logic        w_retire;

  // Every completed SETTLE retires its instruction; skipped words never reach ISSUE.
  assign w_retire = (r_state == ST_SETTLE);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_retired <= '0;
    end else if (w_start) begin
      r_retired <= '0;
    end else if (w_retire && (r_retired != 16'hFFFF)) begin
      r_retired <= r_retired + 16'd1;
    end
  end

  assign bus.retired = r_retired;
`else
  assign bus.retired = '0;
`endif

  assign bus.op_code  = r_op_code;
  assign bus.op_valid = r_op_valid;
  assign bus.rd_sel   = r_rd_sel;
  assign bus.rs_sel   = r_rs_sel;
  assign bus.pc       = r_pc;
  assign bus.busy     = r_busy;
  assign bus.halted   = r_halted;
  assign bus.wr_rej   = r_wr_rej;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed self-checking bench for fetch_sequencer: load/halt, skip, PC wrap,
// rejected write, reset mid-instruction and the optional retire counter.
module tb_fetch_sequencer;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  logic [7:0] prog [16];

  fetch_sequencer_if #(.PC_W(4), .REG_SEL_W(2)) bus ();

  fetch_sequencer #(.PC_W(4), .REG_SEL_W(2)) dut (
    .i_clk   (clk),
    .i_reset (reset),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] addr, input logic [7:0] data);
    bus.wr_en   = 1'b1;
    bus.wr_addr = addr;
    bus.wr_data = data;
    tick();
    bus.wr_en   = 1'b0;
  endtask

  task automatic start();
    bus.run = 1'b1;
    tick();
    bus.run = 1'b0;
  endtask

  // Entered in ISSUE; leaves just after the edge that ends SETTLE.
  task automatic step(input int exp_pc, input logic skip, input logic halt);
    logic [7:0] w;
    w = prog[exp_pc];
    chk("issue_pc", bus.pc, exp_pc);
    chk("issue_op", bus.op_code, w[7:4]);
    chk("issue_valid", bus.op_valid, 1'b1);
    chk("issue_rd", bus.rd_sel, w[3:2]);
    chk("issue_rs", bus.rs_sel, w[1:0]);
    chk("issue_busy", bus.busy, 1'b1);
    tick();
    chk("settle_op", bus.op_code, 4'hF);
    chk("settle_valid", bus.op_valid, 1'b0);
    chk("settle_pc", bus.pc, exp_pc);
    bus.skip_in = skip;
    bus.halt_in = halt;
    tick();
    bus.skip_in = 1'b0;
    bus.halt_in = 1'b0;
  endtask

  task automatic chk_halted(input int exp_pc);
    chk("halt_flag", bus.halted, 1'b1);
    chk("halt_busy", bus.busy, 1'b0);
    chk("halt_pc", bus.pc, exp_pc);
    chk("halt_op", bus.op_code, 4'hF);
    chk("halt_valid", bus.op_valid, 1'b0);
  endtask

  task automatic chk_retired(input int exp);
`ifdef FETCH_RETIRE_CNT_EN
    chk("retired", bus.retired, exp);
`else
    chk("retired_tied", bus.retired, 16'h0000);
`endif
  endtask

  initial begin
    reset       = 1'b1;
    bus.run     = 1'b0;
    bus.wr_en   = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.skip_in = 1'b0;
    bus.halt_in = 1'b0;

    prog[0]  = 8'h06;  // op 0, rd 1, rs 2
    prog[1]  = 8'h2C;  // op 2, rd 3, rs 0
    prog[2]  = 8'hA0;  // halt
    prog[3]  = 8'h91;  // skipif
    prog[4]  = 8'h20;
    prog[5]  = 8'hAB;  // halt, rd 2, rs 3
    for (int i = 6; i < 15; i++) prog[i] = {4'h1, 4'(i)};
    prog[15] = 8'h35;

    #3;
    chk("rst_op", bus.op_code, 4'hF);
    chk("rst_valid", bus.op_valid, 1'b0);
    chk("rst_pc", bus.pc, 4'd0);
    chk("rst_rd", bus.rd_sel, 2'd0);
    chk("rst_rs", bus.rs_sel, 2'd0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_halted", bus.halted, 1'b0);
    chk("rst_wr_rej", bus.wr_rej, 1'b0);
    chk("rst_retired", bus.retired, 16'h0000);
    #9;
    reset = 1'b0;
    tick();

    for (int i = 0; i < 16; i++) wr(4'(i), prog[i]);
    chk("load_idle_busy", bus.busy, 1'b0);

    // Program load and halt
    start();
    step(0, 1'b0, 1'b0);
    step(1, 1'b0, 1'b0);
    step(2, 1'b0, 1'b1);
    chk_halted(2);
    chk_retired(3);

    // Skip from pc 3 over pc 4
    start();
    chk_retired(0);
    step(0, 1'b0, 1'b0);
    step(1, 1'b0, 1'b0);
    step(2, 1'b0, 1'b0);
    step(3, 1'b1, 1'b0);
    chk("skip_pc", bus.pc, 4'd5);
    step(5, 1'b0, 1'b1);
    chk_halted(5);
    chk_retired(5);

    // Three retired instructions with one skip
    start();
    step(0, 1'b0, 1'b0);
    step(1, 1'b1, 1'b0);
    step(3, 1'b0, 1'b1);
    chk_halted(3);
    chk_retired(3);

    // Wrap 15 -> 0
    start();
    chk_retired(0);
    for (int i = 0; i < 16; i++) step(i, 1'b0, 1'b0);
    chk("wrap1_pc", bus.pc, 4'd0);
    step(0, 1'b0, 1'b1);
    chk_halted(0);

    // Wrap 15 -> 1 by skip
    start();
    for (int i = 0; i < 13; i++) step(i, 1'b0, 1'b0);
    step(13, 1'b1, 1'b0);
    step(15, 1'b1, 1'b0);
    chk("wrap2_pc", bus.pc, 4'd1);
    step(1, 1'b0, 1'b1);
    chk_halted(1);

    // Rejected write during ISSUE
    start();
    bus.wr_en   = 1'b1;
    bus.wr_addr = 4'd0;
    bus.wr_data = 8'hFF;
    tick();
    bus.wr_en   = 1'b0;
    chk("wr_rej_pulse", bus.wr_rej, 1'b1);
    bus.halt_in = 1'b1;
    tick();
    bus.halt_in = 1'b0;
    chk("wr_rej_clear", bus.wr_rej, 1'b0);
    chk_halted(0);
    start();
    step(0, 1'b0, 1'b1);
    chk_halted(0);

    // Write wins over run in HALTED
    bus.run = 1'b1;
    wr(4'd7, 8'h77);
    bus.run = 1'b0;
    prog[7] = 8'h77;
    chk("wr_run_halted", bus.halted, 1'b1);
    chk("wr_run_busy", bus.busy, 1'b0);
    chk("wr_run_no_rej", bus.wr_rej, 1'b0);

    // Reset mid-SETTLE, then replay preserved program
    start();
    step(0, 1'b0, 1'b0);
    tick();
    reset = 1'b1;
    #1;
    chk("mid_rst_op", bus.op_code, 4'hF);
    chk("mid_rst_pc", bus.pc, 4'd0);
    chk("mid_rst_busy", bus.busy, 1'b0);
    chk("mid_rst_halted", bus.halted, 1'b0);
    chk("mid_rst_valid", bus.op_valid, 1'b0);
    #2;
    reset = 1'b0;
    tick();
    chk("post_rst_idle", bus.busy, 1'b0);
    start();
    for (int i = 0; i < 8; i++) step(i, 1'b0, 1'b0);
    step(8, 1'b0, 1'b1);
    chk_halted(8);
    chk_retired(9);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
